// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin arbiter sharing one external ALU between two requesters
module alu_rr_arbiter #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [ILEN-1:0] req0_instr,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [ILEN-1:0] req1_instr,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [ILEN-1:0] alu_instr,
    input  logic [XLEN-1:0] alu_out,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [XLEN-1:0] resp_data
);

    logic last_grant;
    logic can_issue;
    logic grant0;
    logic grant1;
    logic xfer;

    // Round-robin grant: issue only when the result register can take a new value
    always_comb begin
        can_issue = !resp_valid || resp_ready;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (!rst && can_issue) begin
            if (req0_valid && req1_valid) begin
                if (last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
        xfer       = grant0 || grant1;
        req0_ready = grant0;
        req1_ready = grant1;
    end

    // Steer the granted requester onto the ALU; idle bus is all zeros
    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_instr = '0;
        if (grant0) begin
            alu_a     = req0_a;
            alu_b     = req0_b;
            alu_instr = req0_instr;
        end else if (grant1) begin
            alu_a     = req1_a;
            alu_b     = req1_b;
            alu_instr = req1_instr;
        end
    end

    // Result register and priority pointer; a new result may replace one being drained
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            last_grant <= 1'b1;
        end else if (xfer) begin
            resp_valid <= 1'b1;
            resp_id    <= grant1;
            resp_data  <= alu_out;
            last_grant <= grant1;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - scoreboard bench for alu_rr_arbiter
module tb_alu_rr_arbiter;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [31:0] ADD = 32'h006283B3;
    localparam logic [31:0] SUB = 32'h406283B3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req0_valid = 1'b0;
    logic            req0_ready;
    logic [XLEN-1:0] req0_a = '0;
    logic [XLEN-1:0] req0_b = '0;
    logic [ILEN-1:0] req0_instr = '0;
    logic            req1_valid = 1'b0;
    logic            req1_ready;
    logic [XLEN-1:0] req1_a = '0;
    logic [XLEN-1:0] req1_b = '0;
    logic [ILEN-1:0] req1_instr = '0;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [ILEN-1:0] alu_instr;
    logic [XLEN-1:0] alu_out;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic            resp_id;
    logic [XLEN-1:0] resp_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN:0] exp_q[$];

    alu_rr_arbiter #(.XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_instr(req0_instr),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_instr(req1_instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_instr(alu_instr), .alu_out(alu_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    // External ALU stand-in: bit 30 of the instruction selects SUB over ADD
    always_comb alu_out = alu_instr[30] ? (alu_a - alu_b) : (alu_a + alu_b);

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; checks readies and ALU mux mid-cycle, queues expected results
    task automatic step(input logic r,
                        input logic v0, input logic [XLEN-1:0] a0, input logic [XLEN-1:0] b0, input logic [ILEN-1:0] i0,
                        input logic v1, input logic [XLEN-1:0] a1, input logic [XLEN-1:0] b1, input logic [ILEN-1:0] i1,
                        input logic rr, input logic e0, input logic e1,
                        input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1);
        @(posedge clk);
        #2;
        rst = r;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_instr = i0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_instr = i1;
        resp_ready = rr;
        @(negedge clk);
        chk("req0_ready", {63'd0, req0_ready}, {63'd0, e0});
        chk("req1_ready", {63'd0, req1_ready}, {63'd0, e1});
        if (e0) begin
            chk("alu_a0", alu_a, a0);
            exp_q.push_back({1'b0, d0});
        end else if (e1) begin
            chk("alu_a1", alu_a, a1);
            exp_q.push_back({1'b1, d1});
        end else begin
            chk("alu_a_idle", alu_a, 64'd0);
            chk("alu_b_idle", alu_b, 64'd0);
            chk("alu_instr_idle", {32'd0, alu_instr}, 64'd0);
        end
    endtask

    // Monitor: every accepted response must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_unexpected: got id %0d data %0h expected none", resp_id, resp_data);
            end else begin
                logic [XLEN:0] e;
                e = exp_q.pop_front();
                chk("resp_id", {63'd0, resp_id}, {63'd0, e[XLEN]});
                chk("resp_data", resp_data, e[XLEN-1:0]);
            end
        end
    end

    initial begin
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 64'd1; req1_a = 64'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_id", {63'd0, resp_id}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
        chk("rst_req1_ready", {63'd0, req1_ready}, 64'd0);

        // ADD via requester 0, then SUB via requester 1 alone
        step(0, 1, 64'h1_0000_0000, 64'd8, ADD, 0, 0, 0, 0, 1, 1, 0, 64'd4294967304, 0);
        step(0, 0, 0, 0, 0, 1, 64'h1_0000_0000, 64'd8, SUB, 1, 0, 1, 0, 64'd4294967288);
        chk("resp_valid_after_add", {63'd0, resp_valid}, 64'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("drained_valid", {63'd0, resp_valid}, 64'd0);

        // Continuous contention: strict alternation starting at 0
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 64'(100 + i), 64'd1, ADD, 1, 64'(200 + i), 64'd50, SUB, 1,
                 (i % 2) == 0, (i % 2) == 1, 64'(101 + i), 64'(150 + i));
        end

        // Backpressure: result (1,153) held, no grants
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 64'd104, 64'd1, ADD, 1, 64'd204, 64'd50, SUB, 0, 0, 0, 0, 0);
            chk("bp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_id", {63'd0, resp_id}, 64'd1);
            chk("bp_data", resp_data, 64'd153);
        end
        step(0, 1, 64'd104, 64'd1, ADD, 1, 64'd204, 64'd50, SUB, 1, 1, 0, 64'd105, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("drain_grant_valid", {63'd0, resp_valid}, 64'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("drain_idle_valid", {63'd0, resp_valid}, 64'd0);

        // Reset with a held result and both requests pending
        step(0, 0, 0, 0, 0, 1, 64'd300, 64'd7, SUB, 1, 0, 1, 0, 64'd293);
        step(1, 1, 64'd9, 64'd9, ADD, 1, 64'd9, 64'd9, ADD, 0, 0, 0, 0, 0);
        exp_q.delete();
        step(0, 1, 64'd5, 64'd6, ADD, 1, 64'd40, 64'd1, SUB, 1, 1, 0, 64'd11, 0);
        chk("post_rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("post_rst_data", resp_data, 64'd0);
        chk("post_rst_id", {63'd0, resp_id}, 64'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one combinational RV64 ALU (operands a, b; 32-bit R-type instruction; 64-bit Output) between two execute requesters. Round-robin arbitration, valid/ready handshakes on both request ports and on the response. Each granted request is launched to the ALU and its result is captured into a one-deep output register. Sits between the issue logic and the shared ALU instance; the ALU itself is external.

Parameters:
XLEN, 64, operand/result width
ILEN, 32, instruction width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle
req0_a  input  XLEN  requester 0 operand a
req0_b  input  XLEN  requester 0 operand b
req0_instr  input  ILEN  requester 0 instruction
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 accepted this cycle
req1_a  input  XLEN  requester 1 operand a
req1_b  input  XLEN  requester 1 operand b
req1_instr  input  ILEN  requester 1 instruction
alu_a  output  XLEN  to ALU a
alu_b  output  XLEN  to ALU b
alu_instr  output  ILEN  to ALU instruction
alu_out  input  XLEN  from ALU Output (combinational)
resp_valid  output  1  result register holds a result
resp_ready  input  1  consumer takes result
resp_id  output  1  requester that owns resp_data
resp_data  output  XLEN  captured ALU result

Behaviour:
- Clock and reset: one clock, clk; rst synchronous, active-high.
- State: a result register (resp_valid, resp_id, resp_data) and a priority pointer last_grant.
- Reset values: resp_valid=0, resp_id=0, resp_data=0, last_grant=1, so requester 0 wins the first contention.
- can_issue = !resp_valid || resp_ready. This allows issue when the result register is empty or is being drained this cycle.
- Grant (combinational) applies only when can_issue:
  - only req0_valid: grant 0.
  - only req1_valid: grant 1.
  - both valid: grant the requester != last_grant.
  - neither valid: no grant.
- reqN_ready = grant_N. A transfer is reqN_valid && reqN_ready. At most one ready is high in any cycle.
- The ALU mux drives alu_a, alu_b and alu_instr from the granted requester. With no grant, all three are driven to 0.
- On a transfer at edge k: resp_data <= alu_out, resp_id <= granted index, resp_valid <= 1, last_grant <= granted index. Latency is 1 cycle; the result is visible after edge k.
- Drain without a new grant (resp_valid && resp_ready, no transfer): resp_valid <= 0. resp_data and resp_id hold their old values.
- Simultaneous drain and grant: the new result replaces the old one in the same edge and resp_valid stays 1. Full throughput is 1 op/cycle.
- Backpressure (resp_valid && !resp_ready): both readies are 0. The result register and last_grant hold.
- Requester inputs need not be held stable after the transfer. Ungranted requesters keep valid asserted; the arbiter does not require operand stability while a requester waits.
- Under continuous contention, grants alternate strictly 0,1,0,1. No requester waits more than 1 grant.
- rst mid-operation: the pending result is discarded, the state returns to reset values, and no ready is asserted during the reset cycle.
- No decoding of the instruction. An unsupported instruction passes through and its alu_out is captured as-is.

Test Plan:
- ADD via req0: a=4294967296, b=8, instr=0x006283B3, resp_ready=1 -> req0_ready=1 that cycle; next cycle resp_valid=1, resp_id=0, resp_data=4294967304.
- SUB via req1 alone: same operands, instr=0x406283B3 -> granted immediately; next cycle resp_id=1, resp_data=4294967288.
- Both valid for 4 cycles after reset, resp_ready=1 -> grant order 0,1,0,1; resp_id sequence 0,1,0,1 with one result per cycle.
- Backpressure: result held, resp_ready=0 for 3 cycles with both requests valid -> both readies 0; resp_data/resp_id unchanged. When resp_ready rises, the new grant and the drain happen in the same cycle and resp_valid stays 1.
- Drain with no requests -> resp_valid falls to 0 next cycle; alu_a=alu_b=alu_instr=0.
- rst asserted while resp_valid=1 and both requests valid -> the next cycle has resp_valid=0, resp_data=0, and the first grant after reset goes to requester 0.
